// File: rtl/gpio_loader_pkg.sv
// ============================================================================
//  Module      : gpio_loader_pkg
//  Description : Shared types and helpers for the GPIO serial chain loader.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gpio_loader_pkg;

    localparam int GPIO_WORD_BITS = 13;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHAIN_RST = 3'd1,
        SHIFT     = 3'd2,
        LOAD      = 3'd3,
        DONE      = 3'd4
    } loader_state_t;

    // Pad-major, MSB-first order over pads NUM_GPIO-1..0 is a plain reversal
    // of the flat image; a second pass (bit_idx >= chain_len) repeats it.
    function automatic int unsigned gpio_image_pos(input int unsigned chain_len,
                                                   input int unsigned bit_idx);
        int unsigned idx;
        idx = (bit_idx >= chain_len) ? (bit_idx - chain_len) : bit_idx;
        return chain_len - 1 - idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/gpio_loader_tick.sv
// ============================================================================
//  Module      : gpio_loader_tick
//  Description : Serial half-period divider; flags first and last cycle of a tick.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpio_loader_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic wb_clk_i,
    input  logic wb_rstn_i,
    input  logic i_clear,
    output logic o_tick,
    output logic o_tick_first
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] r_div;

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rstn_i || i_clear) begin
            r_div <= '0;
        end else if (r_div == C_DIV_LAST) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    assign o_tick       = (r_div == C_DIV_LAST);
    assign o_tick_first = (r_div == '0);

endmodule

`default_nettype wire

// File: rtl/gpio_serial_loader.sv
// ============================================================================
//  Module      : gpio_serial_loader
//  Description : Resets, shifts and loads the daisy-chained GPIO control blocks.
//                Optional readback check: define GPIO_LOADER_VERIFY_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpio_serial_loader
    import gpio_loader_pkg::*;
#(
    parameter int NUM_GPIO  = 19,
    parameter int CLK_DIV   = 4,
    parameter int RST_TICKS = 2
) (
    input  logic                               wb_clk_i,
    input  logic                               wb_rstn_i,
    input  logic                               start,
    input  logic [NUM_GPIO*GPIO_WORD_BITS-1:0] cfg_words,
    output logic                               busy,
    output logic                               done,
    output logic                               serial_clock,
    output logic                               serial_data_out,
    output logic                               serial_load,
    output logic                               serial_resetn
`ifdef GPIO_LOADER_VERIFY_EN
    ,
    input  logic                               serial_data_in,
    output logic                               verify_err
`endif
);

    localparam int unsigned CHAIN_LEN = NUM_GPIO * GPIO_WORD_BITS;
`ifdef GPIO_LOADER_VERIFY_EN
    localparam int unsigned SHIFT_BITS = 2 * CHAIN_LEN;
`else
    localparam int unsigned SHIFT_BITS = CHAIN_LEN;
`endif
    localparam int CNT_W = $clog2(2 * SHIFT_BITS + 1);
    localparam int POS_W = $clog2(CHAIN_LEN);

    localparam logic [CNT_W-1:0] C_RST_LAST   = CNT_W'(RST_TICKS - 1);
    localparam logic [CNT_W-1:0] C_SHIFT_LAST = CNT_W'(2 * SHIFT_BITS - 1);
    localparam logic [CNT_W-1:0] C_LOAD_LAST  = CNT_W'(1);

    loader_state_t    r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             w_accept;
    logic             w_tick;
    logic             w_tick_first;
    logic [CNT_W-1:0] w_bit_idx;
    logic [POS_W-1:0] w_pos;
    logic             w_img_bit;

    logic r_done, r_sclk, r_sdo, r_load, r_resetn;

    assign w_accept  = (r_state == IDLE) && start;
    assign w_bit_idx = r_cnt >> 1;
    assign w_pos     = POS_W'(gpio_image_pos(CHAIN_LEN, 32'(w_bit_idx)));
    assign w_img_bit = cfg_words[w_pos];

    gpio_loader_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .wb_clk_i     (wb_clk_i),
        .wb_rstn_i    (wb_rstn_i),
        .i_clear      (w_accept),
        .o_tick       (w_tick),
        .o_tick_first (w_tick_first)
    );

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rstn_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // r_cnt counts ticks in CHAIN_RST/LOAD and half-bits in SHIFT (bit 0 = high tick).
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = CHAIN_RST;
                    w_cnt_nxt   = '0;
                end
            end
            CHAIN_RST: begin
                if (w_tick) begin
                    if (r_cnt == C_RST_LAST) begin
                        w_state_nxt = SHIFT;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (w_tick) begin
                    if (r_cnt == C_SHIFT_LAST) begin
                        w_state_nxt = LOAD;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            LOAD: begin
                if (w_tick) begin
                    if (r_cnt == C_LOAD_LAST) begin
                        w_state_nxt = DONE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Chain-facing pins are registered, so they trail the state by one cycle.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rstn_i) begin
            r_done   <= 1'b0;
            r_sclk   <= 1'b0;
            r_sdo    <= 1'b0;
            r_load   <= 1'b0;
            r_resetn <= 1'b0;
        end else begin
            r_done   <= (r_state == DONE);
            r_sclk   <= (r_state == SHIFT) && r_cnt[0];
            r_load   <= (r_state == LOAD) && (r_cnt == C_LOAD_LAST);
            r_resetn <= (r_state != CHAIN_RST);
            if ((r_state == SHIFT) && !r_cnt[0] && w_tick_first) begin
                r_sdo <= w_img_bit;
            end
        end
    end

    assign busy            = (r_state != IDLE);
    assign done            = r_done;
    assign serial_clock    = r_sclk;
    assign serial_data_out = r_sdo;
    assign serial_load     = r_load;
    assign serial_resetn   = r_resetn;

`ifdef GPIO_LOADER_VERIFY_EN
    logic r_verify_err;

    // Second pass: the chain returns the first-pass bit at the same image position.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rstn_i) begin
            r_verify_err <= 1'b0;
        end else if (w_accept) begin
            r_verify_err <= 1'b0;
        end else if ((r_state == SHIFT) && r_cnt[0] && w_tick &&
                     (w_bit_idx >= CNT_W'(CHAIN_LEN)) &&
                     (serial_data_in != w_img_bit)) begin
            r_verify_err <= 1'b1;
        end
    end

    assign verify_err = r_verify_err;
`endif

endmodule

`default_nettype wire
